// File: rtl/gpr_file_sb.sv
// gpr_file_sb
//   Parametrised general-register file with an integrated write scoreboard.
//   Decode reserves a destination register (RESV/RD) and the busy bit lets it
//   detect RAW hazards on the read ports; writeback (EN/RW/PW) stores the data
//   and retires the reservation.
//
// Parameters
//   DW      data width
//   AW      address width (depth = 2**AW)
//   NRP     number of read ports (1..4)
//   BYPASS  1: a same-cycle write is forwarded to matching read ports
//   ZERO_R0 1: R0 reads as zero and is never written or reserved
//
// Ports
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset
//   RA        packed read addresses, port i at RA[i*AW +: AW]
//   PO        packed read data,      port i at PO[i*DW +: DW]
//   BUSY      per-port pending-write flag for the addressed register
//   PW/RW/EN  write data / address / enable (EN also retires busy[RW])
//   RESV/RD   reservation request and register to reserve
//   RESV_ACK  reservation accepted this cycle
module gpr_file_sb #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRP     = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NRP*AW-1:0] RA,
  output logic [NRP*DW-1:0] PO,
  output logic [NRP-1:0]    BUSY,
  input  logic [DW-1:0]     PW,
  input  logic [AW-1:0]     RW,
  input  logic              EN,
  input  logic              RESV,
  input  logic [AW-1:0]     RD,
  output logic              RESV_ACK
);

  localparam int unsigned DEPTH  = 2 ** AW;
  localparam bit          HAS_R0 = (ZERO_R0 != 0);
  localparam bit          HAS_BP = (BYPASS != 0);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             rd_is_zero;

  assign rd_is_zero = HAS_R0 && (RD == '0);

  // Reservation acceptance: a busy register can still be reserved when it is
  // retired in the same cycle. A hardwired R0 is always accepted, never marked.
  always_comb begin
    RESV_ACK = 1'b0;
    if (rd_is_zero) begin
      RESV_ACK = RESV;
    end else begin
      RESV_ACK = RESV && (!busy[RD] || (EN && (RW == RD)));
    end
  end

  // Storage and busy bit per register
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(g);

    if (HAS_R0 && (g == 0)) begin : g_zero
      assign regs[g] = '0;
      assign busy[g] = 1'b0;
    end else begin : g_flop
      logic [DW-1:0] q;
      logic          b;
      logic          wr_hit;
      logic          rs_hit;

      assign wr_hit = EN && (RW == IDX);
      assign rs_hit = RESV_ACK && (RD == IDX);

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          q <= '0;
          b <= 1'b0;
        end else begin
          if (wr_hit) begin
            q <= PW;
          end
          // Reservation has priority over a same-cycle retire of the register.
          if (rs_hit) begin
            b <= 1'b1;
          end else if (wr_hit) begin
            b <= 1'b0;
          end
        end
      end

      assign regs[g] = q;
      assign busy[g] = b;
    end
  end

  // Read ports
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0] ra;
    logic [DW-1:0] po;
    logic          bz;

    assign ra = RA[p*AW +: AW];

    always_comb begin
      po = regs[ra];
      bz = busy[ra];
      if (HAS_R0 && (ra == '0)) begin
        po = '0;
        bz = 1'b0;
      end else if (HAS_BP && EN && (RW == ra)) begin
        po = PW;
        bz = 1'b0;
      end
      // Stored state is already clear during reset; this also blocks bypass.
      if (!RST_N) begin
        po = '0;
        bz = 1'b0;
      end
    end

    assign PO[p*DW +: DW] = po;
    assign BUSY[p]        = bz;
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
module tb_gpr_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Default instance: DW=32, AW=5, NRP=2, BYPASS=1, ZERO_R0=1
  logic        rst_n;
  logic [4:0]  ra0, ra1;
  logic [63:0] po;
  logic [1:0]  busy;
  logic [31:0] pw;
  logic [4:0]  rw, rd;
  logic        en, resv, ack;

  gpr_file_sb #(.DW(32), .AW(5), .NRP(2), .BYPASS(1), .ZERO_R0(1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .RA({ra1, ra0}), .PO(po), .BUSY(busy),
    .PW(pw), .RW(rw), .EN(en), .RESV(resv), .RD(rd), .RESV_ACK(ack)
  );

  // Small instance: DW=16, AW=3, NRP=3, BYPASS=0, ZERO_R0=0
  logic        rst_s;
  logic [8:0]  ra_s;
  logic [47:0] po_s;
  logic [2:0]  busy_s;
  logic [15:0] pw_s;
  logic [2:0]  rw_s, rd_s;
  logic        en_s, resv_s, ack_s;

  gpr_file_sb #(.DW(16), .AW(3), .NRP(3), .BYPASS(0), .ZERO_R0(0)) u_small (
    .CLK(clk), .RST_N(rst_s), .RA(ra_s), .PO(po_s), .BUSY(busy_s),
    .PW(pw_s), .RW(rw_s), .EN(en_s), .RESV(resv_s), .RD(rd_s), .RESV_ACK(ack_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] filled(input int unsigned a);
    return (a == 0) ? 32'd0 : 32'(20 + a);
  endfunction

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0; rst_s = 1'b0;
    ra0 = 5'd3; ra1 = 5'd5; pw = 32'hAB; rw = 5'd3; en = 1'b1; resv = 1'b1; rd = 5'd5;
    ra_s = '0; pw_s = '0; rw_s = '0; rd_s = '0; en_s = 1'b0; resv_s = 1'b0;
    #3;
    chk("rst_po0_no_bypass", po[31:0], 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_ack_follows_resv", ack, 64'd1);
    chk("rst_small_po", po_s, 64'd0);
    tick;
    rst_n = 1'b1; rst_s = 1'b1; en = 1'b0; resv = 1'b0;
    #3;
    chk("post_rst_r3_not_written", po[31:0], 64'd0);
    chk("post_rst_r5_not_reserved", busy[1], 64'd0);
    tick;

    // ---------------- fill R1..R31 with 20+i ----------------
    for (int unsigned i = 1; i < 32; i++) begin
      en = 1'b1; rw = 5'(i); pw = 32'(20 + i); ra0 = 5'(i); ra1 = 5'(i - 1);
      #3;
      chk("fill_bypass_po0", po[31:0], 64'(20 + i));
      chk("fill_prev_po1", po[63:32], 64'(filled(i - 1)));
      tick;
    end
    en = 1'b1; rw = 5'd0; pw = 32'd20; ra0 = 5'd0; ra1 = 5'd31;
    #3;
    chk("r0_write_same_cycle", po[31:0], 64'd0);
    chk("r31_stored", po[63:32], 64'd51);
    tick;
    en = 1'b0;
    #3;
    chk("r0_after_write", po[31:0], 64'd0);
    tick;

    // ---------------- write-disable sweep ----------------
    for (int unsigned a = 0; a < 32; a++) begin
      en = 1'b0; pw = 32'(55 + a); rw = 5'(a); ra0 = 5'(a); ra1 = 5'(31 - a);
      #3;
      chk("sweep_po0", po[31:0], 64'(filled(a)));
      chk("sweep_po1", po[63:32], 64'(filled(31 - a)));
      chk("sweep_busy", busy, 64'd0);
      tick;
    end

    // ---------------- scoreboard hazard ----------------
    resv = 1'b1; rd = 5'd7; ra0 = 5'd7; ra1 = 5'd8;
    #3;
    chk("resv7_ack", ack, 64'd1);
    chk("resv7_busy_before_edge", busy[0], 64'd0);
    tick;
    resv = 1'b0;
    #3;
    chk("r7_busy", busy[0], 64'd1);
    chk("r8_not_busy", busy[1], 64'd0);
    chk("r7_data_kept", po[31:0], 64'd27);
    resv = 1'b1;
    #1;
    chk("resv7_again_nack", ack, 64'd0);
    tick;
    resv = 1'b0;
    #3;
    chk("r7_still_busy", busy[0], 64'd1);
    en = 1'b1; rw = 5'd7; pw = 32'hDEADBEEF; ra1 = 5'd7;
    #1;
    chk("retire7_busy_masked", busy, 64'd0);
    chk("retire7_po0_bypass", po[31:0], 64'hDEADBEEF);
    chk("retire7_po1_bypass", po[63:32], 64'hDEADBEEF);
    tick;
    en = 1'b0;
    #3;
    chk("r7_cleared", busy, 64'd0);
    chk("r7_stored", po[31:0], 64'hDEADBEEF);

    // ---------------- same-cycle retire and reserve ----------------
    resv = 1'b1; rd = 5'd9; ra0 = 5'd9;
    #1;
    chk("resv9_ack", ack, 64'd1);
    tick;
    en = 1'b1; rw = 5'd9; pw = 32'h99; resv = 1'b1; rd = 5'd9;
    #3;
    chk("retire_resv9_ack", ack, 64'd1);
    chk("retire_resv9_busy_masked", busy[0], 64'd0);
    tick;
    en = 1'b0; resv = 1'b0;
    #3;
    chk("r9_busy_after", busy[0], 64'd1);
    chk("r9_data", po[31:0], 64'h99);

    // R0 reservation accepted but never recorded
    resv = 1'b1; rd = 5'd0; ra0 = 5'd0;
    #1;
    chk("resv_r0_ack", ack, 64'd1);
    tick;
    resv = 1'b0;
    #3;
    chk("r0_never_busy", busy[0], 64'd0);

    // ---------------- async reset mid-cycle ----------------
    en = 1'b1; rw = 5'd3; pw = 32'd5; resv = 1'b1; rd = 5'd4;
    tick;
    en = 1'b0; resv = 1'b0; ra0 = 5'd3; ra1 = 5'd4;
    #2;
    chk("pre_arst_r3", po[31:0], 64'd5);
    chk("pre_arst_r4_busy", busy[1], 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_r3_zero", po[31:0], 64'd0);
    chk("arst_r4_not_busy", busy[1], 64'd0);
    rst_n = 1'b1;
    tick;
    chk("after_arst_r3", po[31:0], 64'd0);
    chk("after_arst_r4", busy[1], 64'd0);
    en = 1'b1; rw = 5'd3; pw = 32'h77;
    #3;
    chk("after_arst_bypass", po[31:0], 64'h77);
    tick;
    en = 1'b0;
    #3;
    chk("after_arst_write", po[31:0], 64'h77);

    // ---------------- small instance: no bypass, writable R0 ----------------
    ra_s = {3'd0, 3'd0, 3'd0};
    en_s = 1'b1; rw_s = 3'd0; pw_s = 16'h1234;
    #3;
    chk("s_r0_not_yet", po_s[15:0], 64'd0);
    tick;
    en_s = 1'b0;
    #3;
    chk("s_r0_p0", po_s[15:0], 64'h1234);
    chk("s_r0_p1", po_s[31:16], 64'h1234);
    chk("s_r0_p2", po_s[47:32], 64'h1234);
    en_s = 1'b1; rw_s = 3'd5; pw_s = 16'hAAAA;
    tick;
    rw_s = 3'd6; pw_s = 16'h5555;
    tick;
    en_s = 1'b0; ra_s = {3'd6, 3'd5, 3'd0};
    #3;
    chk("s_ind_p0", po_s[15:0], 64'h1234);
    chk("s_ind_p1", po_s[31:16], 64'hAAAA);
    chk("s_ind_p2", po_s[47:32], 64'h5555);
    resv_s = 1'b1; rd_s = 3'd0;
    #1;
    chk("s_resv0_ack", ack_s, 64'd1);
    tick;
    resv_s = 1'b0;
    #3;
    chk("s_r0_busy", busy_s, 64'b001);
    en_s = 1'b1; rw_s = 3'd0; pw_s = 16'hBEEF;
    #1;
    chk("s_retire_busy_unmasked", busy_s, 64'b001);
    chk("s_retire_no_bypass", po_s[15:0], 64'h1234);
    tick;
    en_s = 1'b0;
    #3;
    chk("s_retired_busy", busy_s, 64'd0);
    chk("s_retired_data", po_s[15:0], 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
